// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Optional early-out for divide special cases is enabled by MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int MULDIV_WIDTH   = 32;
    localparam int MULDIV_LATENCY = MULDIV_WIDTH + 2;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative RV32M mul/div: DATA_WIDTH radix-2 steps on a shared 2W shift register, then sign fix.
// Busy covers ITER/FIX; Done pulses one cycle. MULDIV_EARLY_OUT_EN short-cuts div-by-zero/overflow.
module execute_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StartE,
    input  logic                  FlushE,
    input  logic [2:0]            Funct3E,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    input  logic [4:0]            RdE,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result,
    output logic [4:0]            RdM
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    muldiv_state_e r_state;
    muldiv_state_e w_next;

    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_opb;
    logic [W-1:0]   r_srca;
    muldiv_op_e     r_op;
    logic [4:0]     r_rd;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_div_zero;
    logic [W-1:0]   r_result;
    logic [4:0]     r_rdm;

    muldiv_op_e     w_op;
    logic           w_sa;
    logic           w_sb;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic           w_accept;
    logic           w_last;
    logic           w_early;
    logic [W-1:0]   w_early_val;

    assign w_op     = muldiv_op_e'(Funct3E);
    assign w_sa     = op_a_signed(w_op) & SrcAE[W-1];
    assign w_sb     = op_b_signed(w_op) & SrcBE[W-1];
    assign w_mag_a  = w_sa ? -SrcAE : SrcAE;
    assign w_mag_b  = w_sb ? -SrcBE : SrcBE;
    assign w_accept = StartE & ~FlushE & ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == CW'(W - 1));

`ifdef MULDIV_EARLY_OUT_EN
    logic w_dz;
    logic w_ovf;
    assign w_dz  = w_op[2] & (SrcBE == '0);
    assign w_ovf = ((w_op == OP_DIV) || (w_op == OP_REM)) &
                   (SrcAE == {1'b1, {(W-1){1'b0}}}) & (&SrcBE);
    assign w_early     = w_dz | w_ovf;
    assign w_early_val = w_op[1] ? (w_dz ? SrcAE : '0)
                                 : (w_dz ? '1 : {1'b1, {(W-1){1'b0}}});
`else
    assign w_early     = 1'b0;
    assign w_early_val = '0;
`endif

    // Multiply step: add multiplicand into the high half when the low bit is set, then shift right.
    logic           w_carry;
    logic [W-1:0]   w_sum;
    logic [2*W-1:0] w_mul_next;
    assign {w_carry, w_sum} = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : {(W+1){1'b0}});
    assign w_mul_next       = {w_carry, w_sum, r_acc[W-1:1]};

    // Restoring divide step: shift {rem,quot} left, keep the trial subtraction if it did not borrow.
    logic [2*W:0]   w_shl;
    logic [W:0]     w_trial;
    logic [2*W-1:0] w_div_next;
    assign w_shl      = {r_acc, 1'b0};
    assign w_trial    = w_shl[2*W:W] - {1'b0, r_opb};
    assign w_div_next = w_trial[W] ? w_shl[2*W-1:0] : {w_trial[W-1:0], r_acc[W-2:0], 1'b1};

    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_final;
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MUL:                       w_final = w_prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*W-1:W];
            OP_DIV, OP_DIVU:              w_final = r_div_zero ? '1 : w_quot;
            default:                      w_final = r_div_zero ? r_srca : w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) w_next = w_early ? DONE : ITER;
                else          w_next = IDLE;
            end
            ITER:    w_next = FlushE ? IDLE : (w_last ? FIX : ITER);
            FIX:     w_next = FlushE ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state == ITER) || (r_state == FIX);
        Done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_srca     <= '0;
            r_op       <= OP_MUL;
            r_rd       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_result   <= '0;
            r_rdm      <= '0;
        end else begin
            if (w_accept) begin
                r_cnt      <= '0;
                r_acc      <= {{W{1'b0}}, w_mag_a};
                r_opb      <= w_mag_b;
                r_srca     <= SrcAE;
                r_op       <= w_op;
                r_rd       <= RdE;
                r_neg_q    <= w_sa ^ w_sb;
                r_neg_r    <= w_sa;
                r_div_zero <= w_op[2] & (SrcBE == '0);
                if (w_early) begin
                    r_result <= w_early_val;
                    r_rdm    <= RdE;
                end
            end else if (r_state == ITER) begin
                r_acc <= r_op[2] ? w_div_next : w_mul_next;
                r_cnt <= r_cnt + 1'b1;
            end else if ((r_state == FIX) && !FlushE) begin
                r_result <= w_final;
                r_rdm    <= r_rd;
            end
        end
    end

    assign Result = r_result;
    assign RdM    = r_rdm;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed-vector bench for execute_muldiv: results, latency, Busy span, flush, reset and back-to-back.
module tb_execute_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StartE = 1'b0;
    logic        FlushE = 1'b0;
    logic [2:0]  Funct3E = 3'd0;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic [4:0]  RdE = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [4:0]  RdM;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = MULDIV_LATENCY;
`endif

    execute_muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .StartE(StartE), .FlushE(FlushE),
        .Funct3E(Funct3E), .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE),
        .Busy(Busy), .Done(Done), .Result(Result), .RdM(RdM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
        StartE  = 1'b1;
        Funct3E = f3;
        SrcAE   = a;
        SrcBE   = b;
        RdE     = rd;
    endtask

    // Starts an op at a falling edge and follows it to Done, checking value, destination and timing.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        int busy;
        @(negedge clk);
        drive_start(f3, a, b, rd);
        @(negedge clk);
        StartE = 1'b0;
        cyc  = 1;
        busy = 0;
        while (!Done && cyc < 100) begin
            if (Busy) busy++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(Done), 32'd1);
        check({tag, "_latency"},   32'(cyc), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy), 32'(exp_lat - 1));
        check({tag, "_result"}, Result, exp_res);
        check({tag, "_rdm"}, 32'(RdM), 32'(rd));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
        check({tag, "_result_held"}, Result, exp_res);
    endtask

    initial begin
        int cyc;
        int gap;

        repeat (2) @(negedge clk);
        check("reset_busy",   32'(Busy), 32'd0);
        check("reset_done",   32'(Done), 32'd0);
        check("reset_result", Result,    32'd0);
        check("reset_rdm",    32'(RdM),  32'd0);
        rst_n = 1'b1;

        run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MULDIV_LATENCY);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, MULDIV_LATENCY);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, MULDIV_LATENCY);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, MULDIV_LATENCY);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,        5'd9,  32'hFFFF_FFFD, MULDIV_LATENCY);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFF, MULDIV_LATENCY);
        run_op("divu",   3'd5, 32'd100,      32'd7,        5'd11, 32'd14,        MULDIV_LATENCY);
        run_op("remu",   3'd7, 32'd100,      32'd7,        5'd12, 32'd2,         MULDIV_LATENCY);
        run_op("div_by0",  3'd4, 32'd5,      32'd0,        5'd13, 32'hFFFF_FFFF, SPECIAL_LAT);
        run_op("rem_by0",  3'd6, 32'd5,      32'd0,        5'd14, 32'd5,         SPECIAL_LAT);
        run_op("divu_by0", 3'd5, 32'd5,      32'd0,        5'd15, 32'hFFFF_FFFF, SPECIAL_LAT);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, SPECIAL_LAT);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         SPECIAL_LAT);

        // Flush mid-iteration: no Done, previous result kept, next op unaffected.
        @(negedge clk);
        drive_start(3'd5, 32'd1000, 32'd3, 5'd20);
        @(negedge clk);
        StartE = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        check("flush_busy",   32'(Busy), 32'd0);
        check("flush_done",   32'(Done), 32'd0);
        check("flush_result", Result,    32'd0);
        check("flush_rdm",    32'(RdM),  32'd17);
        run_op("after_flush", 3'd0, 32'd12, 32'd12, 5'd21, 32'd144, MULDIV_LATENCY);

        // Asynchronous reset in the middle of an op.
        @(negedge clk);
        drive_start(3'd0, 32'd3, 32'd3, 5'd22);
        @(negedge clk);
        StartE = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy",   32'(Busy), 32'd0);
        check("midreset_done",   32'(Done), 32'd0);
        check("midreset_result", Result,    32'd0);
        check("midreset_rdm",    32'(RdM),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: second op accepted in the DONE cycle of the first.
        @(negedge clk);
        drive_start(3'd5, 32'd100, 32'd7, 5'd3);
        @(negedge clk);
        StartE = 1'b0;
        cyc = 1;
        while (!Done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_latency", 32'(cyc), 32'(MULDIV_LATENCY));
        check("b2b_first_result",  Result,   32'd14);
        drive_start(3'd7, 32'd100, 32'd7, 5'd4);
        @(negedge clk);
        StartE = 1'b0;
        gap = 1;
        check("b2b_done_dropped", 32'(Done), 32'd0);
        check("b2b_busy_second",  32'(Busy), 32'd1);
        while (!Done && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_gap",           32'(gap),  32'(MULDIV_LATENCY));
        check("b2b_second_result", Result,    32'd2);
        check("b2b_second_rdm",    32'(RdM),  32'd4);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
